// File: rtl/bpsk_pkg.sv
// Shared encodings for the BPSK datapath strobe generators.
// Holds the operating modes and the pulse-train FSM states.
package bpsk_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_BURST  = 2'b01,
    MODE_CONT   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } state_t;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter shared by the HIGH and LOW phases.
// tc flags a count of zero, i.e. the last cycle of the current phase.
module phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// Single / burst / continuous pulse train with runtime high, low and count settings.
// Handshake: start is a level sampled only while idle; done is a one-cycle strobe, busy covers HIGH and LOW.
module pulse_train_generator
  import bpsk_pkg::*;
#(
  parameter int   CNT_W      = 16,
  parameter int   NUM_W      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             sig,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_idx,
  output state_t           fsm_state
);

  localparam logic ACTIVE_LEVEL = ~IDLE_LEVEL;

  state_t           state, state_d;
  logic             sig_d, busy_d, done_d;
  logic [NUM_W-1:0] idx_d;

  // Lengths are stored as len-1 so a zero input naturally clamps to one cycle.
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] high_m1_q, low_m1_q;
  logic [NUM_W-1:0] last_idx_q;
  logic [CNT_W-1:0] high_in_m1, low_in_m1;
  logic [NUM_W-1:0] last_in_idx;
  logic             latch_cfg;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_tc;
  logic             is_final;

  assign high_in_m1  = (high_len == '0)   ? '0 : high_len - CNT_W'(1);
  assign low_in_m1   = (low_len == '0)    ? '0 : low_len - CNT_W'(1);
  assign last_in_idx = (num_pulses == '0) ? '0 : num_pulses - NUM_W'(1);

  assign is_final = (mode_q == MODE_BURST) ? (pulse_idx == last_idx_q)
                                           : (mode_q != MODE_CONT);

  phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d   = state;
    sig_d     = IDLE_LEVEL;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    idx_d     = pulse_idx;
    cnt_load  = 1'b0;
    cnt_val   = high_m1_q;
    latch_cfg = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            latch_cfg = 1'b1;
            state_d   = ST_HIGH;
            sig_d     = ACTIVE_LEVEL;
            busy_d    = 1'b1;
            idx_d     = '0;
            cnt_load  = 1'b1;
            cnt_val   = high_in_m1;
          end
        end
        ST_HIGH: begin
          if (!cnt_tc) begin
            sig_d  = ACTIVE_LEVEL;
            busy_d = 1'b1;
          end else if (is_final) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_LOW;
            busy_d   = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = low_m1_q;
          end
        end
        ST_LOW: begin
          busy_d = 1'b1;
          if (cnt_tc) begin
            state_d  = ST_HIGH;
            sig_d    = ACTIVE_LEVEL;
            idx_d    = pulse_idx + NUM_W'(1);
            cnt_load = 1'b1;
            cnt_val  = high_m1_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      sig       <= IDLE_LEVEL;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_idx <= '0;
    end else begin
      state     <= state_d;
      sig       <= sig_d;
      busy      <= busy_d;
      done      <= done_d;
      pulse_idx <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= MODE_SINGLE;
      high_m1_q  <= '0;
      low_m1_q   <= '0;
      last_idx_q <= '0;
    end else if (latch_cfg) begin
      mode_q     <= mode;
      high_m1_q  <= high_in_m1;
      low_m1_q   <= low_in_m1;
      last_idx_q <= last_in_idx;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator: a schedule-based reference model checked every cycle,
// plus hand-computed waveform literals for each scenario.
module tb_pulse_train_generator;
  import bpsk_pkg::*;

  localparam int   CNT_W      = 8;
  localparam int   NUM_W      = 2;
  localparam logic IDLE_LEVEL = 1'b0;
  localparam int   EW         = NUM_W + 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [CNT_W-1:0] high_len = '0;
  logic [CNT_W-1:0] low_len = '0;
  logic [NUM_W-1:0] num_pulses = '0;
  logic             sig, busy, done;
  logic [NUM_W-1:0] pulse_idx;
  state_t           fsm_state;

  int   n_checks = 0;
  int   n_pass = 0;
  logic chk_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pulse_train_generator #(
    .CNT_W      (CNT_W),
    .NUM_W      (NUM_W),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .high_len   (high_len),
    .low_len    (low_len),
    .num_pulses (num_pulses),
    .sig        (sig),
    .busy       (busy),
    .done       (done),
    .pulse_idx  (pulse_idx),
    .fsm_state  (fsm_state)
  );

  // ---------------- reference model ----------------
  // On an accepted start the whole future waveform {sig,busy,done,idx} is laid out in exp_q.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur = '0;

  function automatic logic [EW-1:0] pack(input logic s, input logic b, input logic d,
                                         input logic [NUM_W-1:0] i);
    return {s, b, d, i};
  endfunction

  initial begin
    int h, l, np;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        exp_q.delete();
        cur = pack(IDLE_LEVEL, 1'b0, 1'b0, '0);
      end else if (abort) begin
        exp_q.delete();
        cur = pack(IDLE_LEVEL, 1'b0, 1'b0, cur[NUM_W-1:0]);
      end else if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
      end else if (start) begin
        h  = (high_len == '0) ? 1 : int'(high_len);
        l  = (low_len == '0) ? 1 : int'(low_len);
        if (mode == MODE_BURST)     np = (num_pulses == '0) ? 1 : int'(num_pulses);
        else if (mode == MODE_CONT) np = 64;
        else                        np = 1;
        for (int p = 0; p < np; p++) begin
          logic [31:0] pv;
          pv = p;
          for (int k = 0; k < h; k++) exp_q.push_back(pack(~IDLE_LEVEL, 1'b1, 1'b0, pv[NUM_W-1:0]));
          if (p != np - 1)
            for (int k = 0; k < l; k++) exp_q.push_back(pack(IDLE_LEVEL, 1'b1, 1'b0, pv[NUM_W-1:0]));
          else
            exp_q.push_back(pack(IDLE_LEVEL, 1'b0, 1'b1, pv[NUM_W-1:0]));
        end
        cur = exp_q.pop_front();
      end else begin
        cur = pack(IDLE_LEVEL, 1'b0, 1'b0, cur[NUM_W-1:0]);
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if ({sig, busy, done, pulse_idx} === cur) n_pass++;
      else $display("FAIL cycle_compare t=%0t: sig/busy/done/idx got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                    $time, sig, busy, done, pulse_idx, cur[EW-1], cur[EW-2], cur[EW-3], cur[NUM_W-1:0]);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- driver ----------------
  // Iteration i samples the outputs of cycle i; start/abort driven in iteration i act at the following edge.
  task automatic run_capture(input int n, input logic [31:0] start_m, input logic [31:0] abort_m,
                             input int cfg_at, output logic [31:0] s_tr, output logic [31:0] b_tr,
                             output logic [31:0] d_tr, output logic [31:0] i_tr);
    s_tr = '0; b_tr = '0; d_tr = '0; i_tr = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = start_m[i];
      abort = abort_m[i];
      if (i == cfg_at) begin
        high_len = 8'd9; low_len = 8'd9; mode = MODE_CONT; num_pulses = 2'd3;
      end
      s_tr[i] = sig;
      b_tr[i] = busy;
      d_tr[i] = done;
      i_tr[i*NUM_W +: NUM_W] = pulse_idx;
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] m, input int h, input int l, input int np);
    mode = m; high_len = CNT_W'(h); low_len = CNT_W'(l); num_pulses = NUM_W'(np);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [31:0] s_tr, b_tr, d_tr, i_tr;

    repeat (2) @(negedge clk);
    check("reset_sig", {31'd0, sig}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_idx", {30'd0, pulse_idx}, 32'd0);
    chk_en = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single, high_len=3
    set_cfg(MODE_SINGLE, 3, 5, 0);
    run_capture(6, 32'h1, 32'h0, -1, s_tr, b_tr, d_tr, i_tr);
    check("single_sig", s_tr, 32'b001110);
    check("single_busy", b_tr, 32'b001110);
    check("single_done", d_tr, 32'b010000);

    // burst 2/1/3
    set_cfg(MODE_BURST, 2, 1, 3);
    run_capture(12, 32'h1, 32'h0, -1, s_tr, b_tr, d_tr, i_tr);
    check("burst_sig", s_tr, 32'b000110110110);
    check("burst_busy", b_tr, 32'b000111111110);
    check("burst_done", d_tr, 32'b001000000000);
    check("burst_idx", {8'd0, i_tr[23:0]}, {8'd0, 24'b101010101001010100000000});

    // continuous 1/1, wrap at 4, abort mid-HIGH in cycle 11
    set_cfg(MODE_CONT, 1, 1, 0);
    run_capture(13, 32'h1, 32'h800, -1, s_tr, b_tr, d_tr, i_tr);
    check("cont_sig", s_tr, 32'b0101010101010);
    check("cont_done", d_tr, 32'd0);
    check("cont_busy", b_tr, 32'b0111111111110);
    check("cont_idx", {6'd0, i_tr[25:0]}, {6'd0, 26'b01010000111110100101000010});

    // zero config in burst mode behaves as one 1-cycle pulse
    set_cfg(MODE_BURST, 0, 0, 0);
    run_capture(4, 32'h1, 32'h0, -1, s_tr, b_tr, d_tr, i_tr);
    check("zero_sig", s_tr, 32'b0010);
    check("zero_busy", b_tr, 32'b0010);
    check("zero_done", d_tr, 32'b0100);

    // starts while busy ignored, start in done cycle accepted
    set_cfg(MODE_SINGLE, 3, 1, 0);
    run_capture(12, 32'h1D, 32'h0, -1, s_tr, b_tr, d_tr, i_tr);
    check("retrig_sig", s_tr, 32'b000011101110);
    check("retrig_busy", b_tr, 32'b000011101110);
    check("retrig_done", d_tr, 32'b000100010000);

    // config changes while busy have no effect
    set_cfg(MODE_SINGLE, 2, 1, 0);
    run_capture(6, 32'h1, 32'h0, 1, s_tr, b_tr, d_tr, i_tr);
    check("cfgchg_sig", s_tr, 32'b000110);
    check("cfgchg_done", d_tr, 32'b001000);

    // start and abort together in IDLE
    set_cfg(MODE_SINGLE, 2, 1, 0);
    run_capture(4, 32'h1, 32'h1, -1, s_tr, b_tr, d_tr, i_tr);
    check("startabort_sig", s_tr, 32'd0);
    check("startabort_busy", b_tr, 32'd0);

    // async reset mid-burst
    set_cfg(MODE_BURST, 3, 2, 3);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("async_sig", {31'd0, sig}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
    @(negedge clk); rst = 1'b1;
    run_capture(6, 32'h0, 32'h0, -1, s_tr, b_tr, d_tr, i_tr);
    check("post_reset_sig", s_tr, 32'd0);
    check("post_reset_busy", b_tr, 32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
